// File: rtl/iic_eeprom_resp_if.sv
// ---------------------------------------------------------------------------
// iic_eeprom_resp_if
// Purpose : I2C bus bundle between the iic master and the EEPROM responder.
// Signals : scl, sdo      - I2C clock and master-driven SDA (1 = released)
//           a0, a1, a2    - device-select pins
//           wp            - write-protect pin
//           sdi           - resolved SDA seen by the master
//           sda_oe        - 1 = responder pulls SDA low
//           busy          - responder is engaged in an addressed transfer
// ---------------------------------------------------------------------------
interface iic_eeprom_resp_if;
  logic scl;
  logic sdo;
  logic a0;
  logic a1;
  logic a2;
  logic wp;
  logic sdi;
  logic sda_oe;
  logic busy;

  modport master (
    output scl, sdo, a0, a1, a2, wp,
    input  sdi, sda_oe, busy
  );

  modport slave (
    input  scl, sdo, a0, a1, a2, wp,
    output sdi, sda_oe, busy
  );
endinterface

// File: rtl/iic_eeprom_resp.sv
// ---------------------------------------------------------------------------
// iic_eeprom_resp
// Purpose : 24C02-class I2C EEPROM responder. Oversamples SCL/SDA on sclk,
//           detects START/STOP, decodes device and word address, ACKs, and
//           serves byte/page writes and sequential reads from internal RAM.
// Ports   : sclk  - system clock, rising edge
//           reset - synchronous active-high reset
//           bus   - iic_eeprom_resp_if.slave (scl, sdo, a0..a2, wp in;
//                   sdi, sda_oe, busy out)
// Config  : IIC_EE_WP_EN defined   -> wp=1 NACKs data bytes, RAM untouched.
//           IIC_EE_WP_EN undefined -> wp ignored, all writes committed.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | not addressed; bus ignored until next START
// DEV    | shifting in device address + R/W bit
// DACK   | ACKing device address
// WADR   | shifting in word address
// WACK   | ACKing word address
// WDAT   | shifting in write data byte
// DTACK  | ACK (or wp NACK) of write data; byte committed on its SCL rise
// RDAT   | shifting out read data, MSB first
// MACK   | master ACK/NACK slot after a read byte
// ---------------------------------------------------------------------------
module iic_eeprom_resp #(
  parameter int          ADDR_W = 8,
  parameter int          PAGE_W = 3,
  parameter logic [3:0]  DEV_ID = 4'b1010
) (
  input  logic               sclk,
  input  logic               reset,
  iic_eeprom_resp_if.slave   bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_DACK, S_WADR, S_WACK, S_WDAT, S_DTACK, S_RDAT, S_MACK
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic [7:0]          r_sr, w_sr_nxt;
  logic [7:0]          r_tx, w_tx_nxt;
  logic                r_rw, w_rw_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                r_oe, w_oe_nxt;
  logic                w_we;

  logic [7:0]          r_mem [0:(2**ADDR_W)-1];
  logic [7:0]          w_rd_byte;

  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;
  logic w_scl_rise, w_scl_fall, w_scl_hi;
  logic w_start, w_stop;
  logic w_dev_match;
  logic w_wp;
  logic [ADDR_W-1:0]   w_addr_page_inc;

`ifdef IIC_EE_WP_EN
  assign w_wp = bus.wp;
`else
  logic w_unused_wp;
  assign w_unused_wp = bus.wp;
  assign w_wp        = 1'b0;
`endif

  // Two-flop synchronizer plus one history stage; history resets to the
  // released level so leaving reset never fabricates an edge.
  always_ff @(posedge sclk) begin
    if (reset) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
    end else begin
      r_scl_s1 <= bus.scl; r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
      r_sda_s1 <= bus.sdo; r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  // SCL must be stably high for an SDA edge to count as START/STOP; an SDA
  // edge landing together with an SCL edge is just a data change.
  assign w_scl_hi   = r_scl_s2 & r_scl_d;
  assign w_start    = w_scl_hi & ~r_sda_s2 & r_sda_d;
  assign w_stop     = w_scl_hi & r_sda_s2 & ~r_sda_d;

  assign w_dev_match = (r_sr[7:4] == DEV_ID) &&
                       (r_sr[3:1] == {bus.a2, bus.a1, bus.a0});
  assign w_rd_byte   = r_mem[r_addr];
  // Page writes roll over inside the page; upper address bits stay put.
  assign w_addr_page_inc = {r_addr[ADDR_W-1:PAGE_W],
                            r_addr[PAGE_W-1:0] + PAGE_W'(1)};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sr_nxt    = r_sr;
    w_tx_nxt    = r_tx;
    w_rw_nxt    = r_rw;
    w_addr_nxt  = r_addr;
    w_oe_nxt    = r_oe;
    w_we        = 1'b0;

    if (w_start) begin
      w_state_nxt = S_DEV;
      w_cnt_nxt   = 4'd0;
      w_oe_nxt    = 1'b0;
    end else if (w_stop) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 4'd0;
      w_oe_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_DEV, S_WADR, S_WDAT: begin
          if (w_scl_rise) begin
            w_sr_nxt  = {r_sr[6:0], r_sda_s2};
            w_cnt_nxt = r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            w_cnt_nxt = 4'd0;
            if (r_state == S_DEV) begin
              if (w_dev_match) begin
                w_rw_nxt    = r_sr[0];
                w_state_nxt = S_DACK;
                w_oe_nxt    = 1'b1;
              end else begin
                w_state_nxt = S_IDLE;
              end
            end else if (r_state == S_WADR) begin
              w_addr_nxt  = r_sr[ADDR_W-1:0];
              w_state_nxt = S_WACK;
              w_oe_nxt    = 1'b1;
            end else begin
              w_state_nxt = S_DTACK;
              w_oe_nxt    = ~w_wp;
            end
          end
        end
        S_DACK: begin
          if (w_scl_fall) begin
            w_cnt_nxt = 4'd0;
            if (r_rw) begin
              w_state_nxt = S_RDAT;
              w_tx_nxt    = w_rd_byte;
              w_oe_nxt    = ~w_rd_byte[7];
            end else begin
              w_state_nxt = S_WADR;
              w_oe_nxt    = 1'b0;
            end
          end
        end
        S_WACK: begin
          if (w_scl_fall) begin
            w_state_nxt = S_WDAT;
            w_cnt_nxt   = 4'd0;
            w_oe_nxt    = 1'b0;
          end
        end
        S_DTACK: begin
          if (w_scl_rise) begin
            w_we       = ~w_wp;
            w_addr_nxt = w_addr_page_inc;
          end else if (w_scl_fall) begin
            w_state_nxt = S_WDAT;
            w_cnt_nxt   = 4'd0;
            w_oe_nxt    = 1'b0;
          end
        end
        S_RDAT: begin
          if (w_scl_rise) begin
            w_cnt_nxt = r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            w_state_nxt = S_MACK;
            w_cnt_nxt   = 4'd0;
            w_oe_nxt    = 1'b0;
          end else if (w_scl_fall && r_cnt != 4'd0) begin
            w_tx_nxt = {r_tx[6:0], 1'b0};
            w_oe_nxt = ~r_tx[6];
          end
        end
        S_MACK: begin
          if (w_scl_rise) begin
            if (!r_sda_s2) w_addr_nxt  = r_addr + ADDR_W'(1);
            else           w_state_nxt = S_IDLE;
          end else if (w_scl_fall) begin
            w_state_nxt = S_RDAT;
            w_cnt_nxt   = 4'd0;
            w_tx_nxt    = w_rd_byte;
            w_oe_nxt    = ~w_rd_byte[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sclk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      r_cnt  <= 4'd0;
      r_sr   <= 8'd0;
      r_tx   <= 8'd0;
      r_rw   <= 1'b0;
      r_addr <= '0;
      r_oe   <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_sr   <= w_sr_nxt;
      r_tx   <= w_tx_nxt;
      r_rw   <= w_rw_nxt;
      r_addr <= w_addr_nxt;
      r_oe   <= w_oe_nxt;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge sclk) begin
    if (w_we && !reset) r_mem[r_addr] <= r_sr;
  end

  assign bus.sda_oe = r_oe;
  assign bus.sdi    = bus.sdo & ~r_oe;
  assign bus.busy   = (r_state != S_IDLE) && (r_state != S_DEV);

endmodule
